// File: rtl/fifo_stream_reader.sv
// FIFO read-side drain engine: turns a 1-cycle-latency FIFO read port into a framed valid/ready stream.
// Optional completed-packet counter enabled by defining FIFO_READER_PKTCNT_EN.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_sop,
    output logic                  m_eop
`ifdef FIFO_READER_PKTCNT_EN
    ,
    output logic [15:0]           pkt_cnt
`endif
);

    typedef enum logic {
        S_HDR,
        S_BODY
    } state_t;

    state_t                 state, state_next;
    logic [LEN_WIDTH-1:0]   remain, remain_next;
    logic [DATA_WIDTH-1:0]  head, tail, head_next, tail_next;
    logic [1:0]             occ, occ_next;
    logic                   inflight;
    logic                   hs;
    logic [DATA_WIDTH-1:0]  front;
    logic [2:0]             outstanding;
    logic [LEN_WIDTH-1:0]   len;

    // The word arriving from the FIFO bypasses the empty buffer so a read in cycle t is visible in t+1.
    assign m_valid     = (occ != 2'd0) | inflight;
    assign front       = (occ != 2'd0) ? head : fifo_rd_data;
    assign m_data      = m_valid ? front : '0;
    assign hs          = m_valid & m_ready;
    assign len         = front[LEN_WIDTH-1:0];
    assign outstanding = {1'b0, occ} + {2'b00, inflight} - {2'b00, hs};
    assign fifo_rd_en  = ~rst & ~fifo_empty & (outstanding < 3'd2);

    // Buffer update: the words visible this cycle are head, then tail / returning FIFO data.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        head_next = head;
        tail_next = tail;
        occ_next  = outstanding[1:0];
        case (occ)
            2'd0: if (inflight && !hs) head_next = fifo_rd_data;
            2'd1: begin
                if (inflight) begin
                    if (hs) head_next = fifo_rd_data;
                    else    tail_next = fifo_rd_data;
                end
            end
            2'd2: if (hs) head_next = tail;
            default: ;
        endcase
    end

    // Framing decode; only a handshake advances it, so stalls hold state indefinitely.
    always_comb begin
        state_next  = state;
        remain_next = remain;
        m_sop       = 1'b0;
        m_eop       = 1'b0;
        case (state)
            S_HDR: begin
                m_sop = m_valid;
                m_eop = m_valid & (len == '0);
                if (hs && len != '0) begin
                    state_next  = S_BODY;
                    remain_next = len;
                end
            end
            S_BODY: begin
                m_eop = m_valid & (remain == LEN_WIDTH'(1));
                if (hs) begin
                    if (remain == LEN_WIDTH'(1)) state_next  = S_HDR;
                    else                         remain_next = remain - LEN_WIDTH'(1);
                end
            end
            default: state_next = S_HDR;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_HDR;
            remain   <= '0;
            occ      <= 2'd0;
            inflight <= 1'b0;
            // NOTE: the two data registers are reset too; it is cheap here and keeps m_data defined.
            head     <= '0;
            tail     <= '0;
        end else begin
            state    <= state_next;
            remain   <= remain_next;
            occ      <= occ_next;
            inflight <= fifo_rd_en;
            head     <= head_next;
            tail     <= tail_next;
        end
    end

`ifdef FIFO_READER_PKTCNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              pkt_cnt <= 16'd0;
        else if (hs && m_eop) pkt_cnt <= pkt_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomized self-checking bench for fifo_stream_reader: FIFO model, packet-level expected stream, invariants.
// pkt_cnt checks are included when FIFO_READER_PKTCNT_EN is defined.
module tb_fifo_stream_reader;

    typedef enum int { RDY_ONE, RDY_ZERO, RDY_RAND } ready_mode_t;
    typedef struct {
        logic [15:0] data;
        logic        sop;
        logic        eop;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [15:0] fifo_rd_data = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [15:0] m_data;
    logic        m_sop;
    logic        m_eop;
`ifdef FIFO_READER_PKTCNT_EN
    logic [15:0] pkt_cnt;
`endif

    fifo_stream_reader dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_sop        (m_sop),
        .m_eop        (m_eop)
`ifdef FIFO_READER_PKTCNT_EN
        ,
        .pkt_cnt      (pkt_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // FIFO model with one-cycle read latency
    logic [15:0] mem [4096];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int reads_issued = 0;
    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (rst) begin
            rd_ptr       <= wr_ptr;
            reads_issued <= 0;
        end else if (fifo_rd_en && (rd_ptr != wr_ptr)) begin
            fifo_rd_data <= mem[rd_ptr[11:0]];
            rd_ptr       <= rd_ptr + 1;
            reads_issued <= reads_issued + 1;
        end
    end

    // Ready driver
    ready_mode_t ready_mode = RDY_ZERO;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            RDY_ONE:  m_ready = 1'b1;
            RDY_ZERO: m_ready = 1'b0;
            default:  m_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Expected stream
    beat_t exp_q[$];
    int    exp_pkts = 0;

    task automatic push_word(input logic [15:0] d, input logic sop, input logic eop);
        beat_t b;
        mem[wr_ptr[11:0]] = d;
        wr_ptr++;
        b.data = d;
        b.sop  = sop;
        b.eop  = eop;
        exp_q.push_back(b);
    endtask

    task automatic push_pkt(input logic [15:0] hdr, input logic [15:0] base);
        int n;
        n = int'(hdr[7:0]);
        push_word(hdr, 1'b1, n == 0);
        for (int i = 1; i <= n; i++) push_word(base + 16'(i), 1'b0, i == n);
        exp_pkts++;
    endtask

    // Monitor
    int          cyc = 0;
    int          hs_total = 0;
    int          last_hs_cyc = 0;
    int          accepted = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data;
    logic        prev_sop, prev_eop;

    always @(negedge clk) begin
        beat_t b;
        cyc++;
        if (rst) begin
            accepted   = 0;
            prev_stall = 1'b0;
        end else begin
            check("rd_en_while_empty", 32'(fifo_rd_en & fifo_empty), 32'd0);
            check("flags_without_valid", 32'(!m_valid & (m_sop | m_eop)), 32'd0);
            check("outstanding_le_2", 32'((reads_issued - accepted) <= 2), 32'd1);
            if (prev_stall) begin
                check("stall_valid_held", 32'(m_valid), 32'd1);
                check("stall_data_held", 32'(m_data), 32'(prev_data));
                check("stall_flags_held", {30'd0, m_sop, m_eop}, {30'd0, prev_sop, prev_eop});
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 32'(m_data), 32'hDEAD_BEEF);
                end else begin
                    b = exp_q.pop_front();
                    check("word_data", 32'(m_data), 32'(b.data));
                    check("word_sop", 32'(m_sop), 32'(b.sop));
                    check("word_eop", 32'(m_eop), 32'(b.eop));
                end
                accepted++;
                hs_total++;
                last_hs_cyc = cyc;
            end
            prev_stall = m_valid & ~m_ready;
            prev_data  = m_data;
            prev_sop   = m_sop;
            prev_eop   = m_eop;
        end
    end

    task automatic wait_hs(input int target, input int budget);
        for (int i = 0; i < budget && hs_total < target; i++) @(posedge clk);
        check("hs_wait_timeout", 32'(hs_total >= target), 32'd1);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
        check(tag, 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_idle"}, 32'(m_valid), 32'd0);
`ifdef FIFO_READER_PKTCNT_EN
        check({tag, "_pkt_cnt"}, 32'(pkt_cnt), 32'(exp_pkts));
`endif
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"}, 32'(m_valid), 32'd0);
        check({tag, "_data"}, 32'(m_data), 32'd0);
        check({tag, "_sop_eop"}, {30'd0, m_sop, m_eop}, 32'd0);
        check({tag, "_rd_en"}, 32'(fifo_rd_en), 32'd0);
`ifdef FIFO_READER_PKTCNT_EN
        check({tag, "_pkt_cnt"}, 32'(pkt_cnt), 32'd0);
`endif
    endtask

    initial begin
        int h0, c0;
        // Reset state, with the FIFO already non-empty
        push_word(16'h1234, 1'b1, 1'b0);
        #1;
        check_outputs_zero("reset");
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        exp_q.delete();

        // Header 3 with payload A1..A3, 4 back-to-back words
        @(posedge clk);
        ready_mode = RDY_ONE;
        #2;
        h0 = hs_total;
        push_pkt(16'h0003, 16'h00A0);
        wait_hs(h0 + 1, 50);
        c0 = last_hs_cyc;
        wait_drain("t1_drain", 50);
        check("t1_burst_span", 32'(last_hs_cyc - c0), 32'd3);

        // Zero-length packet then header 1 with payload B0
        push_pkt(16'h0000, 16'h0000);
        push_pkt(16'h0001, 16'h00AF);
        wait_drain("t2_drain", 50);

        // 10 words, random ready with a 20-cycle hold-low
        @(posedge clk);
        ready_mode = RDY_RAND;
        #2;
        push_pkt({8'($urandom), 8'd3}, 16'($urandom));
        push_pkt({8'($urandom), 8'd0}, 16'($urandom));
        push_pkt({8'($urandom), 8'd4}, 16'($urandom));
        repeat (6) @(posedge clk);
        ready_mode = RDY_ZERO;
        repeat (20) @(posedge clk);
        ready_mode = RDY_RAND;
        wait_drain("t3_drain", 200);

        // Header 5 fed one word at a time with the FIFO emptying in between
        @(posedge clk);
        ready_mode = RDY_ONE;
        #2;
        push_word(16'h0005, 1'b1, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            repeat ($urandom_range(3, 8)) @(posedge clk);
            #2;
            push_word(16'h00C0 + 16'(i), 1'b0, i == 5);
        end
        exp_pkts++;
        wait_drain("t4_drain", 50);

        // Reset in S_BODY with two words buffered
        @(posedge clk);
        ready_mode = RDY_ZERO;
        #2;
        push_pkt(16'h0005, 16'h00D0);
        repeat (4) @(posedge clk);
        ready_mode = RDY_ONE;
        @(posedge clk);
        ready_mode = RDY_ZERO;
        repeat (3) @(posedge clk);
        #2;
        check("t5_pre_reset_body", 32'(m_valid & ~m_sop), 32'd1);
        rst = 1'b1;
        #1;
        exp_q.delete();
        exp_pkts = 0;
        check_outputs_zero("t5_reset");
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        ready_mode = RDY_ONE;
        #2;
        push_pkt(16'h0002, 16'h00E0);
        wait_drain("t5_drain", 50);

        // Two back-to-back 256-word packets at full rate
        h0 = hs_total;
        push_pkt(16'h00FF, 16'h1000);
        push_pkt(16'h00FF, 16'h2000);
        wait_hs(h0 + 1, 50);
        c0 = last_hs_cyc;
        wait_drain("t6_drain", 1000);
        check("t6_burst_span", 32'(last_hs_cyc - c0), 32'd511);

        // Random soak: random packets, random ready, staggered arrival
        @(posedge clk);
        ready_mode = RDY_RAND;
        for (int p = 0; p < 30; p++) begin
            #2;
            push_pkt({8'($urandom), 8'($urandom_range(0, 7))}, 16'($urandom));
            repeat ($urandom_range(0, 6)) @(posedge clk);
        end
        wait_drain("soak_drain", 2000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
